// File: rtl/storer_pkg.sv
// Shared CPU package: fetch-side state and source constants plus the
// store-path state encoding and default datapath widths.
// Optional readback verification is selected with the STORER_READBACK_EN macro.
package storer_pkg;

  // Default datapath widths used by the CPU blocks
  localparam int STORE_BITS_DEF      = 8;
  localparam int STORE_ADDR_BITS_DEF = 8;

  // Fetch source selectors
  localparam logic FETCH_ROM = 1'b0;
  localparam logic FETCH_RAM = 1'b1;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_ADDR = 2'd1,
    FETCH_DATA = 2'd2
  } fetch_state_e;

  // Store sequencer states
  typedef enum logic [2:0] {
    STORE_IDLE       = 3'd0,
    STORE_SETUP      = 3'd1,
    STORE_WRITE      = 3'd2,
    STORE_VERIFY_RD  = 3'd3,
    STORE_VERIFY_CMP = 3'd4,
    STORE_DONE       = 3'd5
  } store_state_e;

  // Reload value of the write-hold counter: counts down to zero across the
  // write pulse, so a pulse of n cycles starts at n-1.
  function automatic logic [3:0] store_hold_init(input int we_cycles);
    return 4'(we_cycles - 1);
  endfunction

endpackage

// File: rtl/storer.sv
// Store sequencer: latches an address/data pair on request, presents it to
// the RAM for one setup cycle, holds the write enable for WE_CYCLES cycles,
// optionally reads the word back and flags a mismatch, then pulses done.
// Macro STORER_READBACK_EN enables the VERIFY_RD/VERIFY_CMP readback states.
module storer
  import storer_pkg::*;
#(
  parameter int BITS      = STORE_BITS_DEF,
  parameter int ADDR_BITS = STORE_ADDR_BITS_DEF,
  parameter int WE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 store_req,
  input  logic [ADDR_BITS-1:0] store_addr,
  input  logic [BITS-1:0]      store_data,
  input  logic [BITS-1:0]      mem_rdata,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [BITS-1:0]      mem_wdata,
  output logic                 mem_we,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  // The hold counter is 4 bits wide, so the pulse length must fit 1..15.
  if ((WE_CYCLES < 1) || (WE_CYCLES > 15)) begin : g_bad_we_cycles
    $error("storer: WE_CYCLES must be in the range 1..15");
  end

  localparam logic [3:0] HOLD_INIT = store_hold_init(WE_CYCLES);

  store_state_e          state_r;
  store_state_e          state_s;
  logic [3:0]            hold_r;
  logic [3:0]            hold_s;
  logic                  accept_s;
  logic                  err_r;
  logic                  err_s;
  logic [ADDR_BITS-1:0]  addr_r;
  logic [BITS-1:0]       data_r;
  logic                  we_r;
  logic                  busy_r;
  logic                  done_r;

`ifndef STORER_READBACK_EN
  // Read data only matters when readback is built in.
  logic unused_rdata_s;
  assign unused_rdata_s = ^mem_rdata;
`endif

  // Next-state, hold counter and error-flag logic for the store sequence
  always_comb begin
    state_s  = state_r;
    hold_s   = hold_r;
    accept_s = 1'b0;
    err_s    = err_r;
    case (state_r)
      STORE_IDLE: begin
        if (store_req) begin
          accept_s = 1'b1;
          state_s  = STORE_SETUP;
        end else begin
          state_s  = STORE_IDLE;
        end
      end
      STORE_SETUP: begin
        hold_s  = HOLD_INIT;
        state_s = STORE_WRITE;
      end
      STORE_WRITE: begin
        if (hold_r == 4'd0) begin
`ifdef STORER_READBACK_EN
          state_s = STORE_VERIFY_RD;
`else
          state_s = STORE_DONE;
`endif
        end else begin
          hold_s  = hold_r - 4'd1;
          state_s = STORE_WRITE;
        end
      end
`ifdef STORER_READBACK_EN
      STORE_VERIFY_RD: begin
        state_s = STORE_VERIFY_CMP;
      end
      STORE_VERIFY_CMP: begin
        if (mem_rdata != data_r) begin
          err_s = 1'b1;
        end else begin
          err_s = err_r;
        end
        state_s = STORE_DONE;
      end
`endif
      STORE_DONE: begin
        // A request in the done cycle chains straight into the next store.
        if (store_req) begin
          accept_s = 1'b1;
          state_s  = STORE_SETUP;
        end else begin
          state_s  = STORE_IDLE;
        end
      end
      default: begin
        state_s = STORE_IDLE;
      end
    endcase
    // The error flag is sticky until the next accepted request.
    if (accept_s) begin
      err_s = 1'b0;
    end else begin
      err_s = err_s;
    end
`ifndef STORER_READBACK_EN
    err_s = 1'b0;
`endif
  end

  // State, counter and registered outputs; outputs are decoded from the
  // next state so they line up with the state they describe
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= STORE_IDLE;
      hold_r  <= 4'd0;
      we_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      hold_r  <= hold_s;
      we_r    <= (state_s == STORE_WRITE);
      busy_r  <= (state_s != STORE_IDLE);
      done_r  <= (state_s == STORE_DONE);
      err_r   <= err_s;
    end
  end

  // Capture address and data on acceptance; they stay on the RAM bus
  // until the next accepted request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_r <= '0;
      data_r <= '0;
    end else if (accept_s) begin
      addr_r <= store_addr;
      data_r <= store_data;
    end else begin
      addr_r <= addr_r;
      data_r <= data_r;
    end
  end

  assign mem_addr  = addr_r;
  assign mem_wdata = data_r;
  assign mem_we    = we_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;

endmodule

// File: tb/tb_storer.sv
// Bench for storer: one instance with a 1-cycle write pulse, one with a
// 3-cycle pulse, each with its own RAM model. Expected stores are queued
// when requests are driven and checked when done pulses.
module tb_storer;

`ifdef STORER_READBACK_EN
  localparam int RB = 1;
`else
  localparam int RB = 0;
`endif

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic       err;
  } exp_t;

  typedef struct {
    int         k;
    logic [7:0] a;
    logic [7:0] d;
    logic       c;
    int         lat;
    logic       e;
  } vec_t;

  logic       clk;
  logic       reset;
  logic       req     [2];
  logic [7:0] addr_in [2];
  logic [7:0] data_in [2];
  logic       corrupt [2];
  logic [7:0] mem_addr  [2];
  logic [7:0] mem_wdata [2];
  logic       mem_we    [2];
  logic       busy      [2];
  logic       done      [2];
  logic       err       [2];
  logic [7:0] rdata0;
  logic [7:0] rdata1;
  logic [7:0] ram0 [256];
  logic [7:0] ram1 [256];

  exp_t q0[$];
  exp_t q1[$];
  int   run     [2];
  logic [7:0] wr_addr [2];
  logic [7:0] wr_data [2];

  int total = 0;
  int bad   = 0;

  storer #(.BITS(8), .ADDR_BITS(8), .WE_CYCLES(1)) u_dut0 (
    .clk(clk), .reset(reset), .store_req(req[0]), .store_addr(addr_in[0]),
    .store_data(data_in[0]), .mem_rdata(rdata0), .mem_addr(mem_addr[0]),
    .mem_wdata(mem_wdata[0]), .mem_we(mem_we[0]), .busy(busy[0]),
    .done(done[0]), .err(err[0])
  );

  storer #(.BITS(8), .ADDR_BITS(8), .WE_CYCLES(3)) u_dut1 (
    .clk(clk), .reset(reset), .store_req(req[1]), .store_addr(addr_in[1]),
    .store_data(data_in[1]), .mem_rdata(rdata1), .mem_addr(mem_addr[1]),
    .mem_wdata(mem_wdata[1]), .mem_we(mem_we[1]), .busy(busy[1]),
    .done(done[1]), .err(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models with synchronous read; corrupt flips bit 0 of read data
  always @(posedge clk) begin
    if (mem_we[0]) ram0[mem_addr[0]] <= mem_wdata[0];
    rdata0 <= ram0[mem_addr[0]] ^ {7'd0, corrupt[0]};
  end

  always @(posedge clk) begin
    if (mem_we[1]) ram1[mem_addr[1]] <= mem_wdata[1];
    rdata1 <= ram1[mem_addr[1]] ^ {7'd0, corrupt[1]};
  end

  function automatic int we_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [7:0] ram_rd(input int k, input logic [7:0] a);
    return (k == 0) ? ram0[a] : ram1[a];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int k, input logic [7:0] a, input logic [7:0] d, input logic e);
    exp_t x;
    x.addr = a;
    x.data = d;
    x.err  = e;
    if (k == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  // Scoreboard: watch the write pulse and compare against the queue on done
  always @(negedge clk) begin
    if (reset) begin
      run[0] = 0;
      run[1] = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (mem_we[k]) begin
          if (run[k] != 0) begin
            check("we_stable_addr", {24'd0, mem_addr[k]}, {24'd0, wr_addr[k]});
            check("we_stable_data", {24'd0, mem_wdata[k]}, {24'd0, wr_data[k]});
          end
          run[k]++;
          wr_addr[k] = mem_addr[k];
          wr_data[k] = mem_wdata[k];
        end
        if (done[k]) begin
          if (((k == 0) && (q0.size() == 0)) || ((k == 1) && (q1.size() == 0))) begin
            total++;
            bad++;
            $display("FAIL sb_empty: dut%0d done with no store pending at %0t", k, $time);
          end else begin
            exp_t x;
            if (k == 0) x = q0.pop_front();
            else        x = q1.pop_front();
            check("sb_addr", {24'd0, wr_addr[k]}, {24'd0, x.addr});
            check("sb_data", {24'd0, wr_data[k]}, {24'd0, x.data});
            check("sb_we_len", run[k], we_of(k));
            check("sb_ram", {24'd0, ram_rd(k, x.addr)}, {24'd0, x.data});
            check("sb_err", {31'd0, err[k]}, {31'd0, x.err});
          end
          run[k] = 0;
        end
      end
    end
  end

  // One complete store from idle, with latency and idle-state checks
  task automatic do_store(input vec_t v);
    int cnt;
    @(negedge clk);
    req[v.k]     = 1'b1;
    addr_in[v.k] = v.a;
    data_in[v.k] = v.d;
    corrupt[v.k] = v.c;
    push_exp(v.k, v.a, v.d, v.e);
    @(negedge clk);
    req[v.k] = 1'b0;
    check("setup_busy", {31'd0, busy[v.k]}, 32'd1);
    check("setup_we", {31'd0, mem_we[v.k]}, 32'd0);
    check("setup_addr", {24'd0, mem_addr[v.k]}, {24'd0, v.a});
    check("setup_err", {31'd0, err[v.k]}, 32'd0);
    cnt = 1;
    while (!done[v.k] && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    check("latency", cnt, v.lat);
    @(negedge clk);
    check("idle_busy", {31'd0, busy[v.k]}, 32'd0);
    check("idle_done", {31'd0, done[v.k]}, 32'd0);
    check("idle_we", {31'd0, mem_we[v.k]}, 32'd0);
    check("idle_addr_hold", {24'd0, mem_addr[v.k]}, {24'd0, v.a});
    check("idle_data_hold", {24'd0, mem_wdata[v.k]}, {24'd0, v.d});
    check("idle_err_sticky", {31'd0, err[v.k]}, {31'd0, v.e});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[9];
    int   p;
    int   seen;
    vecs[0] = '{0, 8'h05, 8'hA5, 1'b0, 3 + 2 * RB, 1'b0};
    vecs[1] = '{0, 8'h00, 8'h3C, 1'b0, 3 + 2 * RB, 1'b0};
    vecs[2] = '{0, 8'hFF, 8'hC3, 1'b0, 3 + 2 * RB, 1'b0};
    vecs[3] = '{1, 8'hFF, 8'h00, 1'b0, 5 + 2 * RB, 1'b0};
    vecs[4] = '{1, 8'h00, 8'hFF, 1'b0, 5 + 2 * RB, 1'b0};
    vecs[5] = '{1, 8'h80, 8'h5A, 1'b0, 5 + 2 * RB, 1'b0};
    vecs[6] = '{0, 8'h7F, 8'h01, 1'b0, 3 + 2 * RB, 1'b0};
    vecs[7] = '{0, 8'h33, 8'h77, 1'b1, 3 + 2 * RB, (RB == 1)};
    vecs[8] = '{0, 8'h34, 8'h78, 1'b0, 3 + 2 * RB, 1'b0};

    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req[k]     = 1'b0;
      addr_in[k] = 8'h00;
      data_in[k] = 8'h00;
      corrupt[k] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("rst_we", {31'd0, mem_we[k]}, 32'd0);
      check("rst_busy", {31'd0, busy[k]}, 32'd0);
      check("rst_done", {31'd0, done[k]}, 32'd0);
      check("rst_err", {31'd0, err[k]}, 32'd0);
      check("rst_addr", {24'd0, mem_addr[k]}, 32'd0);
      check("rst_wdata", {24'd0, mem_wdata[k]}, 32'd0);
    end
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      do_store(vecs[i]);
    end

    // Request held high with alternating addresses: stores chain through
    // the done cycle and requests during a store are dropped
    p = 3 + 2 * RB;
    corrupt[0] = 1'b0;
    for (int i = 0; i < 3 * p; i++) begin
      @(negedge clk);
      if (i > 0) check("chain_busy", {31'd0, busy[0]}, 32'd1);
      req[0]     = 1'b1;
      addr_in[0] = ((i % 2) == 0) ? 8'h10 : 8'h11;
      data_in[0] = 8'(i) + 8'h20;
      if ((i % p) == 0) push_exp(0, addr_in[0], data_in[0], 1'b0);
    end
    @(negedge clk);
    req[0] = 1'b0;
    check("chain_last_done", {31'd0, done[0]}, 32'd1);
    @(negedge clk);
    check("chain_idle", {31'd0, busy[0]}, 32'd0);
    check("chain_all_done", q0.size(), 32'd0);

    // Reset between clock edges in the middle of a 3-cycle write pulse
    @(negedge clk);
    req[1]     = 1'b1;
    addr_in[1] = 8'h44;
    data_in[1] = 8'h99;
    @(negedge clk);
    req[1] = 1'b0;
    @(negedge clk);
    check("pre_rst_we", {31'd0, mem_we[1]}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_we", {31'd0, mem_we[1]}, 32'd0);
    check("async_rst_busy", {31'd0, busy[1]}, 32'd0);
    check("async_rst_done", {31'd0, done[1]}, 32'd0);
    check("async_rst_addr", {24'd0, mem_addr[1]}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (done[1]) seen++;
    end
    check("rst_no_done", seen, 0);
    do_store('{1, 8'h45, 8'h9A, 1'b0, 5 + 2 * RB, 1'b0});
    check("final_q1_empty", q1.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
